// File: rtl/gsim_pe_pipe.sv
// Gauss-Seidel stencil PE: out = floor((b + (in_1+in_2) - 6*(in_3+in_4) + 13*(in_5+in_6)) / 20)
// Four-stage valid/ready pipeline with a global stall, carried tag, and optional saturation.
module gsim_pe_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16,
  parameter int B_W    = 16,
  parameter int TAG_W  = 8,
  parameter bit SAT    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_1,
  input  logic signed [DATA_W-1:0] in_2,
  input  logic signed [DATA_W-1:0] in_3,
  input  logic signed [DATA_W-1:0] in_4,
  input  logic signed [DATA_W-1:0] in_5,
  input  logic signed [DATA_W-1:0] in_6,
  input  logic signed [B_W-1:0]    b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int P_W   = DATA_W + 1;
  localparam int BA_W  = B_W + FRAC;
  localparam int M6_W  = DATA_W + 4;
  localparam int M13_W = DATA_W + 5;
  // Wide enough for the stencil sum and for a large aligned bias.
  localparam int T_W   = (DATA_W + 6 > BA_W + 2) ? DATA_W + 6 : BA_W + 2;
  localparam logic signed [T_W-1:0] DIV   = T_W'(20);
  localparam logic signed [T_W-1:0] ONE   = T_W'(1);
  localparam logic signed [T_W-1:0] Q_MAX = {{(T_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] Q_MIN = {{(T_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic adv;

  logic                     s1_v_q, s2_v_q, s3_v_q, out_valid_q, ovf_q;
  logic [TAG_W-1:0]         s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;
  logic signed [P_W-1:0]    s1_p12_q, s1_p34_q, s1_p56_q, s2_p12_q;
  logic signed [BA_W-1:0]   s1_b_q, s2_b_q;
  logic signed [M6_W-1:0]   s2_m6_q;
  logic signed [M13_W-1:0]  s2_m13_q;
  logic signed [T_W-1:0]    s3_sum_q;
  logic signed [DATA_W-1:0] out_q;

  logic signed [P_W-1:0]    p12_d, p34_d, p56_d;
  logic signed [BA_W-1:0]   b_d;
  logic signed [M6_W-1:0]   p34_x, m6_d;
  logic signed [M13_W-1:0]  p56_x, m13_d;
  logic signed [T_W-1:0]    sum_d, quot, rem, q_fl;
  logic                     q_hi, q_lo, ovf_d;
  logic signed [DATA_W-1:0] res_d;

  // The whole pipe freezes while a result waits on the output.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  assign p12_d = {in_1[DATA_W-1], in_1} + {in_2[DATA_W-1], in_2};
  assign p34_d = {in_3[DATA_W-1], in_3} + {in_4[DATA_W-1], in_4};
  assign p56_d = {in_5[DATA_W-1], in_5} + {in_6[DATA_W-1], in_6};
  assign b_d   = {b, {FRAC{1'b0}}};

  assign p34_x = {{3{s1_p34_q[P_W-1]}}, s1_p34_q};
  assign p56_x = {{4{s1_p56_q[P_W-1]}}, s1_p56_q};
  assign m6_d  = (p34_x <<< 2) + (p34_x <<< 1);
  assign m13_d = (p56_x <<< 3) + (p56_x <<< 2) + p56_x;

  assign sum_d = {{(T_W-BA_W){s2_b_q[BA_W-1]}}, s2_b_q}
               + {{(T_W-P_W){s2_p12_q[P_W-1]}}, s2_p12_q}
               - {{(T_W-M6_W){s2_m6_q[M6_W-1]}}, s2_m6_q}
               + {{(T_W-M13_W){s2_m13_q[M13_W-1]}}, s2_m13_q};

  // Signed division truncates toward zero; step down one for negative inexact quotients.
  assign quot = s3_sum_q / DIV;
  assign rem  = s3_sum_q % DIV;
  assign q_fl = (rem != '0 && s3_sum_q[T_W-1]) ? quot - ONE : quot;
  assign q_hi = q_fl > Q_MAX;
  assign q_lo = q_fl < Q_MIN;

  generate
    if (SAT) begin : g_sat
      assign res_d = q_hi ? Q_MAX[DATA_W-1:0] : (q_lo ? Q_MIN[DATA_W-1:0] : q_fl[DATA_W-1:0]);
    end else begin : g_wrap
      assign res_d = q_fl[DATA_W-1:0];
    end
  endgenerate

  assign ovf_d = (ovf_q && !clr_ovf) || (adv && s3_v_q && (q_hi || q_lo));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      s3_tag_q    <= '0;
      out_tag_q   <= '0;
      s1_p12_q    <= '0;
      s1_p34_q    <= '0;
      s1_p56_q    <= '0;
      s1_b_q      <= '0;
      s2_p12_q    <= '0;
      s2_b_q      <= '0;
      s2_m6_q     <= '0;
      s2_m13_q    <= '0;
      s3_sum_q    <= '0;
      out_q       <= '0;
    end else begin
      if (adv) begin
        s1_v_q      <= in_valid;
        s1_tag_q    <= in_tag;
        s1_p12_q    <= p12_d;
        s1_p34_q    <= p34_d;
        s1_p56_q    <= p56_d;
        s1_b_q      <= b_d;
        s2_v_q      <= s1_v_q;
        s2_tag_q    <= s1_tag_q;
        s2_p12_q    <= s1_p12_q;
        s2_b_q      <= s1_b_q;
        s2_m6_q     <= m6_d;
        s2_m13_q    <= m13_d;
        s3_v_q      <= s2_v_q;
        s3_tag_q    <= s2_tag_q;
        s3_sum_q    <= sum_d;
        out_valid_q <= s3_v_q;
        out_tag_q   <= s3_tag_q;
        out_q       <= res_d;
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_tag   = out_tag_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gsim_pe_pipe.sv
// Scoreboard bench for gsim_pe_pipe: three instances (32-bit saturating, 32-bit wrapping,
// 24-bit saturating) share one stimulus stream and are checked against an arithmetic model.
module tb_gsim_pe_pipe;

  logic        clk, reset, in_valid, out_ready, clr_ovf;
  logic [31:0] cur_d [6];
  logic [15:0] cur_b;
  logic [7:0]  cur_tag;

  logic        rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, ovf_a, ovf_b, ovf_c;
  logic [31:0] out_a, out_b;
  logic [23:0] out_c;
  logic [7:0]  tag_a, tag_b, tag_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] ea, eb, ec;
    bit          ra, rb, rc;
  } exp_t;
  exp_t sb[$];

  gsim_pe_pipe #(.DATA_W(32), .FRAC(16), .B_W(16), .TAG_W(8), .SAT(1'b1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_1(cur_d[0]), .in_2(cur_d[1]), .in_3(cur_d[2]), .in_4(cur_d[3]), .in_5(cur_d[4]), .in_6(cur_d[5]),
    .b(cur_b), .in_tag(cur_tag), .out_valid(ov_a), .out_ready(out_ready),
    .out(out_a), .out_tag(tag_a), .ovf(ovf_a), .clr_ovf(clr_ovf));

  gsim_pe_pipe #(.DATA_W(32), .FRAC(16), .B_W(16), .TAG_W(8), .SAT(1'b0)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_1(cur_d[0]), .in_2(cur_d[1]), .in_3(cur_d[2]), .in_4(cur_d[3]), .in_5(cur_d[4]), .in_6(cur_d[5]),
    .b(cur_b), .in_tag(cur_tag), .out_valid(ov_b), .out_ready(out_ready),
    .out(out_b), .out_tag(tag_b), .ovf(ovf_b), .clr_ovf(clr_ovf));

  gsim_pe_pipe #(.DATA_W(24), .FRAC(8), .B_W(16), .TAG_W(8), .SAT(1'b1)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
    .in_1(cur_d[0][23:0]), .in_2(cur_d[1][23:0]), .in_3(cur_d[2][23:0]),
    .in_4(cur_d[3][23:0]), .in_5(cur_d[4][23:0]), .in_6(cur_d[5][23:0]),
    .b(cur_b), .in_tag(cur_tag), .out_valid(ov_c), .out_ready(out_ready),
    .out(out_c), .out_tag(tag_c), .ovf(ovf_c), .clr_ovf(clr_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] x, input int w);
    longint v;
    v = longint'(x) & ((longint'(1) <<< w) - 1);
    if (x[w-1]) v = v - (longint'(1) <<< w);
    return v;
  endfunction

  // Reference: exact rational result rounded toward -inf, then range handling.
  function automatic void model(input logic [31:0] d [6], input logic [15:0] bb, input int w,
                                input int frac, input bit sat, output logic [31:0] res, output bit rng);
    longint a [6];
    longint t, r, qq, hi, lo;
    for (int i = 0; i < 6; i++) a[i] = sx(d[i], w);
    t  = sx({16'h0, bb}, 16) * (longint'(1) <<< frac)
       + a[0] + a[1] - 6 * (a[2] + a[3]) + 13 * (a[4] + a[5]);
    r  = ((t % 20) + 20) % 20;
    qq = (t - r) / 20;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    rng = (qq > hi) || (qq < lo);
    if (sat && qq > hi) qq = hi;
    else if (sat && qq < lo) qq = lo;
    res = 32'(qq & ((longint'(1) <<< w) - 1));
  endfunction

  // One clock of stimulus, entered and left at posedge+1; returns whether the sample was taken.
  task automatic drive_cycle(input bit v, input bit ordy, input bit clr, output bit acc);
    exp_t e;
    in_valid  = v;
    out_ready = ordy;
    clr_ovf   = clr;
    @(negedge clk);
    #1;
    acc = v && rdy_a;
    if (acc) begin
      e.tag = cur_tag;
      model(cur_d, cur_b, 32, 16, 1'b1, e.ea, e.ra);
      model(cur_d, cur_b, 32, 16, 1'b0, e.eb, e.rb);
      model(cur_d, cur_b, 24, 8, 1'b1, e.ec, e.rc);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic set_vec(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] v3, input logic [31:0] v4, input logic [31:0] v5,
                         input logic [15:0] bb, input logic [7:0] tg);
    cur_d[0] = v0; cur_d[1] = v1; cur_d[2] = v2;
    cur_d[3] = v3; cur_d[4] = v4; cur_d[5] = v5;
    cur_b = bb; cur_tag = tg;
  endtask

  // Single sample with an exact latency check on the first instance.
  task automatic send_lat(input string nm, input logic [31:0] exp_out);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 50) begin
      drive_cycle(1'b1, 1'b1, 1'b0, acc);
      k++;
    end
    chk({nm, "_accept"}, longint'(acc), 1);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk({nm, "_lat"}, longint'(ov_a), longint'(c == 4));
    end
    chk({nm, "_out"}, longint'(out_a), longint'(exp_out));
    chk({nm, "_tag"}, longint'(tag_a), longint'(cur_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stim(input int n);
    logic [31:0] ext [6];
    logic [31:0] v;
    ext[0] = 32'h7FFFFFFF; ext[1] = 32'h80000000; ext[2] = 32'h007FFFFF;
    ext[3] = 32'hFF800000; ext[4] = 32'hFFFFFFFF; ext[5] = 32'h00000000;
    for (int i = 0; i < 6; i++) begin
      case ($urandom % 4)
        0: v = ext[$urandom % 6];
        1: begin
          v = $urandom_range(0, 1 << 20);
          if ($urandom % 2 == 1) v = -v;
        end
        default: v = $urandom;
      endcase
      cur_d[i] = v;
    end
    cur_b   = 16'($urandom);
    cur_tag = 8'(n);
  endtask

  // Monitor: checks every presented result against the scoreboard and tracks sticky ovf.
  initial begin
    exp_t e;
    bit pv, px, pc, nw;
    bit eo_a, eo_b, eo_c;
    pv = 0; px = 0; pc = 0; eo_a = 0; eo_b = 0; eo_c = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_valid", longint'({ov_a, ov_b, ov_c}), 0);
        chk("rst_ovf", longint'({ovf_a, ovf_b, ovf_c}), 0);
        sb.delete();
        pv = 0; px = 0; pc = 0; eo_a = 0; eo_b = 0; eo_c = 0;
      end else begin
        nw = ov_a && (!pv || px);
        if (pc) begin
          eo_a = 0; eo_b = 0; eo_c = 0;
        end
        chk("valid_bc", longint'({ov_b, ov_c}), longint'({ov_a, ov_a}));
        chk("in_ready", longint'(rdy_a), longint'(!(ov_a && !out_ready)));
        chk("in_ready_bc", longint'({rdy_b, rdy_c}), longint'({rdy_a, rdy_a}));
        if (ov_a) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stale: out_valid with tag %0h, expected no result", tag_a);
          end else begin
            e = sb[0];
            if (nw) begin
              eo_a = eo_a | e.ra;
              eo_b = eo_b | e.rb;
              eo_c = eo_c | e.rc;
            end
            chk("out_a", longint'(out_a), longint'(e.ea));
            chk("out_b", longint'(out_b), longint'(e.eb));
            chk("out_c", longint'({8'h0, out_c}), longint'(e.ec));
            chk("tag", longint'({tag_a, tag_b, tag_c}), longint'({e.tag, e.tag, e.tag}));
          end
        end
        chk("ovf_a", longint'(ovf_a), longint'(eo_a));
        chk("ovf_b", longint'(ovf_b), longint'(eo_b));
        chk("ovf_c", longint'(ovf_c), longint'(eo_c));
        pv = ov_a;
        px = ov_a && out_ready;
        pc = clr_ovf;
        if (px && sb.size() > 0) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bit acc;
    int n, cyc;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", longint'(rdy_a), 1);
    @(posedge clk);
    #1;

    // Basic transfer, bias, negative floor
    set_vec(32'h00010000, 32'h00010000, 0, 0, 0, 0, 16'd0, 8'h11);
    send_lat("single", 32'h00001999);
    set_vec(0, 0, 0, 0, 0, 0, 16'd20, 8'h12);
    send_lat("bias", 32'h00010000);
    set_vec(0, 0, 32'h00010000, 32'h00010000, 0, 0, 16'd0, 8'h13);
    send_lat("negfloor", 32'hFFFF6666);
    idle(2);

    // Saturation, sticky flag, clear
    set_vec(0, 0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 16'd32767, 8'h14);
    send_lat("sat", 32'h7FFFFFFF);
    idle(3);
    @(negedge clk);
    chk("ovf_sticky", longint'({ovf_a, ovf_b}), 3);
    @(posedge clk);
    #1;
    drive_cycle(1'b0, 1'b1, 1'b1, acc);
    @(negedge clk);
    chk("ovf_cleared", longint'({ovf_a, ovf_b}), 0);
    @(posedge clk);
    #1;

    // Backpressure: ten tagged samples, out_ready low for three cycles mid-stream
    cyc = 0;
    for (int t = 0; t < 10; t++) begin
      set_vec(32'(t * 4096), 32'(t * 77), 32'(-t * 1000), 32'(t), 32'(t * 9000), 0, 16'(t), 8'(t));
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
        drive_cycle(1'b1, !(cyc >= 6 && cyc < 9), 1'b0, acc);
        cyc++;
        n++;
      end
      chk("bp_accept", longint'(acc), 1);
    end
    idle(10);

    // Reset mid-stream with ovf already set
    set_vec(0, 0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 16'd32767, 8'h20);
    send_lat("sat2", 32'h7FFFFFFF);
    for (int t = 0; t < 3; t++) begin
      set_vec(32'(t + 1), 0, 0, 0, 0, 0, 16'd1, 8'(8'h30 + t));
      drive_cycle(1'b1, 1'b1, 1'b0, acc);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", longint'({ov_a, ov_b, ov_c}), 0);
    chk("async_rst_ovf", longint'({ovf_a, ovf_b, ovf_c}), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", longint'(rdy_a), 1);
    @(posedge clk);
    #1;
    set_vec(32'h00010000, 32'h00010000, 0, 0, 0, 0, 16'd0, 8'hA5);
    send_lat("post_rst", 32'h00001999);
    idle(8);

    // Random regression
    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      rand_stim(n);
      drive_cycle($urandom % 5 != 0, $urandom % 4 != 0, $urandom % 64 == 0, acc);
      if (acc) n++;
      cyc++;
    end
    chk("rand_count", longint'(n), 10000);

    cyc = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && cyc < 20) begin
      idle(1);
      cyc++;
    end
    chk("drain", longint'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
